// File: rtl/spi_pkg.sv
// Shared types and defaults for the system-clocked SPI slave.
package spi_pkg;

    localparam int SPI_DW       = 12;
    localparam int SPI_SYNC_DEF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        SHIFT   = 2'd2,
        WAIT_CS = 2'd3
    } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous level with one-clk rise/fall pulses.
// The pulses compare the last synchronised stage against its previous value.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the asynchronous input through the synchroniser and keep one extra sample for edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave_txrx.sv
// Full-duplex SPI slave, oversampled on the system clock. LSB-first frames of DW bits.
// Optional macro SPI_SLV_OVERRUN_EN enables the sticky overrun flag; otherwise overrun is 0.
module spi_slave_txrx
    import spi_pkg::*;
#(
    parameter int DW          = SPI_DW,
    parameter int SYNC_STAGES = SPI_SYNC_DEF  // must be at least 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          cs,
    input  logic          mosi,
    output logic          miso,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_we,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic          frame_err,
    output logic          overrun
);

    localparam int             CW       = $clog2(DW + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(DW);

    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;

    spi_slv_state_t state_q;
    logic [DW-1:0]  tx_hold_q, tx_shift_q, rx_shift_q, rx_data_q;
    logic [CW-1:0]  cnt_q;
    logic           miso_q, rx_valid_q, frame_err_q;

    logic [CW-1:0]  cnt_d;
    logic [DW-1:0]  rx_shift_d;
    logic           frame_done, accept;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (cs),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // mosi needs the same delay as sclk so data and fall edge stay aligned, but no edge detect.
    always_ff @(posedge clk) begin
        if (rst) mosi_sync_q <= '0;
        else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign cnt_d      = cnt_q + 1'b1;
    assign rx_shift_d = {mosi_s, rx_shift_q[DW-1:1]};
    assign frame_done = (state_q == SHIFT) && (cnt_q == CNT_FULL);
    assign accept     = rx_valid_q && rx_ready;

    // Response holding register; captured into tx_shift only at the start of a frame.
    always_ff @(posedge clk) begin
        if (rst)        tx_hold_q <= '0;
        else if (tx_we) tx_hold_q <= tx_data;
    end

    // Frame FSM with registered miso, rx word, valid flag and abort pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (accept) rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    // cs_fall wins over a coincident sclk_rise: the frame is not armed yet.
                    if (cs_fall) begin
                        tx_shift_q <= tx_hold_q;
                        cnt_q      <= '0;
                        state_q    <= ARMED;
                    end
                end
                ARMED: begin
                    if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        miso_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (sclk_rise) begin
                        miso_q  <= tx_shift_q[0];
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (frame_done) begin
                        // A completed word overrides a pending accept so no data is lost.
                        rx_data_q  <= rx_shift_q;
                        rx_valid_q <= 1'b1;
                        miso_q     <= 1'b0;
                        state_q    <= cs_rise ? IDLE : WAIT_CS;
                    end else if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        miso_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        if (sclk_fall) begin
                            rx_shift_q <= rx_shift_d;
                            cnt_q      <= cnt_d;
                        end
                        if (sclk_rise) miso_q <= tx_shift_q[cnt_q];
                    end
                end
                WAIT_CS: begin
                    miso_q <= 1'b0;
                    if (cs_rise) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SPI_SLV_OVERRUN_EN
    logic overrun_q;

    // Sticky: a word landed while the previous one was still unaccepted.
    always_ff @(posedge clk) begin
        if (rst)                                         overrun_q <= 1'b0;
        else if (frame_done && rx_valid_q && !rx_ready)  overrun_q <= 1'b1;
    end
    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign miso      = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/spi_slave_txrx.md
Name: spi_slave_txrx

Overview:
- Full-duplex SPI slave, fully synchronous to the system clock.
- Oversamples sclk, cs and mosi from the existing 12-bit SPI master.
- Deserialises the 12-bit LSB-first word on mosi and, in the same frame, serialises a 12-bit response LSB-first on miso.
- Sits at the far end of the SPI link as the system-clocked replacement for the sclk-clocked slave, with a valid/ready word interface to local logic.

Parameters:
- DW, 12: frame width in bits.
- SYNC_STAGES, 2: flops in each input synchroniser (minimum 2).

Ports:
- clk  in  1  system clock; sclk must be at least 8x slower.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock from master, asynchronous.
- cs  in  1  chip select, active low, asynchronous.
- mosi  in  1  serial data from master.
- miso  out  1  serial response to master.
- tx_data  in  DW  response word for the next frame.
- tx_we  in  1  write strobe: loads tx_data into the tx holding register.
- rx_data  out  DW  last received word.
- rx_valid  out  1  rx_data valid; held until accepted.
- rx_ready  in  1  consumer accept.
- frame_err  out  1  one-clk pulse: cs deasserted mid-frame.
- overrun  out  1  sticky overrun flag (see Optional Feature).

Behaviour:
- Reset, all synchronous: miso=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, tx holding register=0, shift registers=0, bit count=0, state=IDLE.
- Synchronisers: sclk, cs and mosi each pass through SYNC_STAGES flops.
- Edge detect: sclk_rise/sclk_fall and cs_fall/cs_rise are one-clk pulses generated from the last synchronised stage and its previous value.
- Tx holding register: tx_we loads tx_data in any state; the value takes effect from the next frame.
- FSM states: IDLE, ARMED, SHIFT, WAIT_CS.
- IDLE: on cs_fall, copy the tx holding register into tx_shift, clear bit count, go to ARMED.
- ARMED: the master drives bit0 on the first sclk rise after cs falls. On that sclk_rise: miso<=tx_shift[0], go to SHIFT.
- SHIFT, on sclk_fall: rx_shift<={mosi_sync, rx_shift[DW-1:1]}; count increments.
- SHIFT, on sclk_rise with count<DW: miso<=tx_shift[count].
- SHIFT, frame complete: when count reaches DW after the fall, rx_data<=assembled word and rx_valid<=1 on the following clk, then go to WAIT_CS.
- Latency: rx_valid rises 2 clk after the synchronised 12th sclk fall.
- WAIT_CS: miso held 0; on cs_rise go to IDLE. Further sclk edges are ignored.
- Abort: cs_rise in ARMED or SHIFT -> frame_err pulses 1 clk, rx_data and rx_valid unchanged, miso<=0, go to IDLE.
- Handshake: rx_valid&&rx_ready clears rx_valid the same edge.
- Simultaneous accept and completion: rx_valid stays 1 with the new data; this is not an overrun.
- Simultaneous cs_fall and sclk_rise in IDLE: only cs_fall is acted on.
- Count width: $clog2(DW+1). Wrap-around is impossible because the count is cleared on entry to ARMED.
- Reset mid-frame: immediate return to IDLE. The rest of the frame is ignored until cs rises and falls again.

Optional Feature:
- Macro: SPI_SLV_OVERRUN_EN.
- Defined: a completed frame while rx_valid=1 and rx_ready=0 sets overrun=1. overrun is sticky until rst; rx_data is still overwritten.
- Undefined: overrun tied 0, and rx_data is overwritten silently.

Decomposition:
- Package spi_pkg: state enum spi_slv_state_t (2-bit), localparam SPI_DW=12, localparam SPI_SYNC_DEF=2.
- One sub-module, spi_sync_edge: an N-stage synchroniser plus rise/fall pulse outputs, instantiated for sclk and cs; mosi uses a synchroniser only.

Test Plan:
- Basic frame: tx_we with tx_data=12'hA5C; master sends din=12'h3C7 -> rx_data=12'h3C7, rx_valid=1, bits captured on miso LSB-first reassemble to 12'hA5C.
- Back-to-back: frames 12'h001 then 12'hFFF with rx_ready=1 -> two rx_valid events with correct data each, no overrun.
- Abort: cs forced high after 5 bits of 12'h555 -> frame_err pulses 1 clk, rx_valid stays 0, and the next full frame 12'h123 is received correctly.
- Overrun: with the macro defined, rx_ready=0 across two frames 12'h0F0 and 12'h00F -> overrun=1, rx_data=12'h00F. With the macro undefined -> overrun=0.
- Reset mid-frame: rst for 1 clk after 6 bits -> all outputs at reset values; the next frame 12'h7E1 is received correctly.
- Default response: no tx_we after reset -> miso stays 0 for the whole frame.
